mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Clk  in  1  Single clock; all state updates on the rising edge (the regfile writes on the falling edge of the same Clk).
REQ-002 Rst_n  in  1  Asynchronous, active-low reset.
REQ-003 valid_m, RegWrite_m  in  1 each  MEM-stage instruction valid; MEM-stage instruction writes rd.
REQ-004 rd_m  in  5  MEM-stage destination register.
REQ-005 wb_sel_m  in  2  Result select: 00 ALU, 01 load, 10 PC+4, 11 CSR.
REQ-006 alu_m, pc_m, csr_rdata_m, dmem_rdata_m  in  32 each  ALU result (also the load address); PC; CSR read data; raw data-memory word.
REQ-007 funct3_m  in  3  Load type.
REQ-008 stall, flush  in  1 each  Hold the stage register; kill the instruction entering the stage.
REQ-009 instret_we_lo, instret_we_hi  in  1 each  CSR writes to instret[31:0] / instret[63:32].
REQ-010 instret_wdata  in  32  CSR write data.
REQ-011 waddr  out  5  Drives regfile waddr.
REQ-012 wdata  out  32  Drives regfile wdata.
REQ-013 RegWrite  out  1  Drives regfile RegWrite.
REQ-014 fwd_valid  out  1  WB forwarding source is usable.
REQ-015 fwd_rd  out  5  WB forwarding destination register.
REQ-016 fwd_data  out  32  WB forwarding data.
REQ-017 instret  out  64  Retired-instruction count for the CSR file.

Function
REQ-018 Stage register fields: valid_w, RegWrite_w, rd_w, wb_sel_w, alu_w, pc_w, csr_w, mem_w, funct3_w.
REQ-019 Each edge, priority order: flush loads valid_w=0 and RegWrite_w=0, other fields don't-care; else stall holds all fields; else the stage register loads all *_m inputs.
REQ-020 Flush and stall in the same cycle: flush wins.
REQ-021 wdata is combinational from registered fields: 00 alu_w; 01 aligned load; 10 pc_w+4, wrapping modulo 2^32; 11 csr_w.
REQ-022 Load alignment uses off = alu_w[1:0], little-endian.
REQ-023 LB/LBU (000/100): byte mem_w[8*off+7 : 8*off], sign- or zero-extended.
REQ-024 LH/LHU (001/101): half at alu_w[1] (0 -> [15:0], 1 -> [31:16]), sign- or zero-extended; alu_w[0] ignored.
REQ-025 LW (010) and all other funct3 values: mem_w unchanged.
REQ-026 RegWrite = valid_w & RegWrite_w & (rd_w != 0); waddr = rd_w.
REQ-027 fwd_valid = RegWrite; fwd_rd = rd_w; fwd_data = wdata; no extra latency.
REQ-028 While stalled with a valid instruction, RegWrite stays asserted; rewriting the same value is permitted.
REQ-029 instret increments by 1 on each edge where valid_w=1 and stall=0, including when flush=1, and wraps from 2^64-1 to 0.
REQ-030 A CSR write to a half replaces that half and suppresses the increment on that edge; the other half holds unless also written.

Reset
REQ-031 Rst_n low asynchronously clears every stage field and instret to 0; hence RegWrite=0, fwd_valid=0, waddr=0, wdata=0, instret=0.
REQ-032 Reset asserted mid-operation discards the in-flight instruction with no regfile write; the first post-reset capture occurs on the first rising edge with Rst_n high.

Structure
REQ-033 wb_sel encodings and load funct3 constants SHALL live in the shared core package, not locally.
REQ-034 Load alignment SHALL be one combinational sub-module load_align (mem_w, funct3_w, off -> 32-bit result); all state stays in mem_wb_stage.

Verification
REQ-035 ALU write: valid_m=1, RegWrite_m=1, rd_m=5, wb_sel_m=00, alu_m=0x1234 -> next cycle waddr=5, wdata=0x1234, RegWrite=1, instret+1.
REQ-036 Loads with dmem_rdata_m=0x80FF7F01: LB off=1 -> 0x0000007F; LB off=2 -> 0xFFFFFFFF; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01.
REQ-037 rd_m=0 with RegWrite_m=1 -> RegWrite=0 and fwd_valid=0; instret still increments.
REQ-038 stall=1 and flush=1 on the same edge -> valid_w=0, RegWrite=0; stall alone for 3 cycles -> outputs held and instret advances only on release.
REQ-039 instret=0xFFFFFFFF_FFFFFFFF, then a valid retire -> instret=0; instret_we_lo=1 with instret_wdata=0x10 on a retire edge -> low half = 0x10, no increment.
REQ-040 Rst_n asserted between edges while valid_w=1 -> RegWrite drops immediately and instret=0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared core constants: writeback result select and load funct3 encodings.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_CSR  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bus: MEM-side inputs, pipeline control, instret CSR access,
// and the regfile / forwarding outputs of the WB stage.
interface mem_wb_stage_if;
  logic        valid_m;
  logic        RegWrite_m;
  logic [4:0]  rd_m;
  logic [1:0]  wb_sel_m;
  logic [31:0] alu_m;
  logic [31:0] pc_m;
  logic [31:0] csr_rdata_m;
  logic [31:0] dmem_rdata_m;
  logic [2:0]  funct3_m;
  logic        stall;
  logic        flush;
  logic        instret_we_lo;
  logic        instret_we_hi;
  logic [31:0] instret_wdata;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        RegWrite;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  modport master (
    output valid_m, RegWrite_m, rd_m, wb_sel_m, alu_m, pc_m, csr_rdata_m,
           dmem_rdata_m, funct3_m, stall, flush, instret_we_lo,
           instret_we_hi, instret_wdata,
    input  waddr, wdata, RegWrite, fwd_valid, fwd_rd, fwd_data, instret
  );

  modport slave (
    input  valid_m, RegWrite_m, rd_m, wb_sel_m, alu_m, pc_m, csr_rdata_m,
           dmem_rdata_m, funct3_m, stall, flush, instret_we_lo,
           instret_we_hi, instret_wdata,
    output waddr, wdata, RegWrite, fwd_valid, fwd_rd, fwd_data, instret
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Little-endian load alignment: picks byte/half from the raw memory word
// and sign- or zero-extends it according to the load funct3.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] mem_w,
  input  logic [2:0]  funct3_w,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half, then extend by load type.
  always_comb begin
    byte_sel = mem_w[7:0];
    unique case (off)
      2'd0: byte_sel = mem_w[7:0];
      2'd1: byte_sel = mem_w[15:8];
      2'd2: byte_sel = mem_w[23:16];
      2'd3: byte_sel = mem_w[31:24];
    endcase
    half_sel = off[1] ? mem_w[31:16] : mem_w[15:0];
    result   = mem_w;
    case (funct3_w)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = mem_w;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback mux, WB forwarding source and the
// retired-instruction counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic           Clk,
  input  logic           Rst_n,
  mem_wb_stage_if.slave  bus
);

  logic        valid_w;
  logic        regwrite_w;
  logic [4:0]  rd_w;
  wb_sel_e     wb_sel_w;
  logic [31:0] alu_w;
  logic [31:0] pc_w;
  logic [31:0] csr_w;
  logic [31:0] mem_w;
  logic [2:0]  funct3_w;
  logic [31:0] load_data;
  logic [31:0] wdata_c;
  logic [63:0] instret_q;
  logic        reg_we;

  // Stage register: flush kills, else stall holds, else capture MEM stage.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_w    <= 1'b0;
      regwrite_w <= 1'b0;
      rd_w       <= '0;
      wb_sel_w   <= WB_ALU;
      alu_w      <= '0;
      pc_w       <= '0;
      csr_w      <= '0;
      mem_w      <= '0;
      funct3_w   <= '0;
    end else if (bus.flush) begin
      valid_w    <= 1'b0;
      regwrite_w <= 1'b0;
    end else if (!bus.stall) begin
      valid_w    <= bus.valid_m;
      regwrite_w <= bus.RegWrite_m;
      rd_w       <= bus.rd_m;
      wb_sel_w   <= wb_sel_e'(bus.wb_sel_m);
      alu_w      <= bus.alu_m;
      pc_w       <= bus.pc_m;
      csr_w      <= bus.csr_rdata_m;
      mem_w      <= bus.dmem_rdata_m;
      funct3_w   <= bus.funct3_m;
    end
  end

  // Retire counter: a CSR write to either half replaces that half and
  // suppresses the increment for this edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instret_q <= '0;
    end else if (bus.instret_we_lo || bus.instret_we_hi) begin
      if (bus.instret_we_lo) instret_q[31:0]  <= bus.instret_wdata;
      if (bus.instret_we_hi) instret_q[63:32] <= bus.instret_wdata;
    end else if (valid_w && !bus.stall) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  load_align u_load_align (
    .mem_w    (mem_w),
    .funct3_w (funct3_w),
    .off      (alu_w[1:0]),
    .result   (load_data)
  );

  // Writeback result select.
  always_comb begin
    wdata_c = alu_w;
    case (wb_sel_w)
      WB_ALU:  wdata_c = alu_w;
      WB_LOAD: wdata_c = load_data;
      WB_PC4:  wdata_c = pc_w + 32'd4;
      WB_CSR:  wdata_c = csr_w;
      default: wdata_c = alu_w;
    endcase
  end

  assign reg_we        = valid_w & regwrite_w & (rd_w != 5'd0);
  assign bus.RegWrite  = reg_we;
  assign bus.waddr     = rd_w;
  assign bus.wdata     = wdata_c;
  assign bus.fwd_valid = reg_we;
  assign bus.fwd_rd    = rd_w;
  assign bus.fwd_data  = wdata_c;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage with a behavioural reference model,
// plus directed literal checks of alignment, retire counting and reset.
module tb_mem_wb_stage;

  logic Clk;
  logic Rst_n;
  int   total;
  int   bad;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model state: the instruction sitting in WB and the counter.
  logic        m_valid;
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [31:0] m_alu, m_pc, m_csr, m_mem;
  logic [2:0]  m_f3;
  logic [63:0] m_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (mem >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (mem >> (16 * off[1])) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata();
    if (m_sel == 2'd0) return m_alu;
    if (m_sel == 2'd1) return ref_load(m_mem, m_f3, m_alu[1:0]);
    if (m_sel == 2'd2) return m_pc + 32'd4;
    return m_csr;
  endfunction

  // Model update on each edge from the spec's priority rules.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_rd <= '0; m_sel <= '0;
      m_alu <= '0; m_pc <= '0; m_csr <= '0; m_mem <= '0; m_f3 <= '0;
      m_instret <= '0;
    end else begin
      if (bus.instret_we_lo || bus.instret_we_hi)
        m_instret <= {bus.instret_we_hi ? bus.instret_wdata : m_instret[63:32],
                      bus.instret_we_lo ? bus.instret_wdata : m_instret[31:0]};
      else if (m_valid && !bus.stall)
        m_instret <= m_instret + 64'd1;
      if (bus.flush) begin
        m_valid <= 1'b0; m_rw <= 1'b0;
      end else if (!bus.stall) begin
        m_valid <= bus.valid_m; m_rw <= bus.RegWrite_m; m_rd <= bus.rd_m;
        m_sel <= bus.wb_sel_m; m_alu <= bus.alu_m; m_pc <= bus.pc_m;
        m_csr <= bus.csr_rdata_m; m_mem <= bus.dmem_rdata_m; m_f3 <= bus.funct3_m;
      end
    end
  end

  // Compare process: outputs are registered-only, sampled on the falling edge.
  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("RegWrite", 64'(bus.RegWrite), 64'(m_valid && m_rw && (m_rd != 5'd0)));
      chk("fwd_valid", 64'(bus.fwd_valid), 64'(m_valid && m_rw && (m_rd != 5'd0)));
      chk("instret", bus.instret, m_instret);
      if (m_valid) begin
        chk("waddr", 64'(bus.waddr), 64'(m_rd));
        chk("fwd_rd", 64'(bus.fwd_rd), 64'(m_rd));
        chk("wdata", 64'(bus.wdata), 64'(ref_wdata()));
        chk("fwd_data", 64'(bus.fwd_data), 64'(ref_wdata()));
      end
    end
  end

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic set_instr(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                           input logic [2:0] f3, input logic [31:0] mem);
    bus.valid_m = 1'b1; bus.RegWrite_m = 1'b1; bus.rd_m = rd; bus.wb_sel_m = sel;
    bus.alu_m = alu; bus.funct3_m = f3; bus.dmem_rdata_m = mem;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]  ld_f3  [5] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
  logic [1:0]  ld_off [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
  logic [31:0] ld_exp [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                              32'hFFFF_80FF, 32'h0000_7F01};

  initial begin
    total = 0; bad = 0;
    Rst_n = 1'b0;
    bus.valid_m = 0; bus.RegWrite_m = 0; bus.rd_m = '0; bus.wb_sel_m = '0;
    bus.alu_m = '0; bus.pc_m = '0; bus.csr_rdata_m = '0; bus.dmem_rdata_m = '0;
    bus.funct3_m = '0; bus.stall = 0; bus.flush = 0;
    bus.instret_we_lo = 0; bus.instret_we_hi = 0; bus.instret_wdata = '0;
    step(); step();
    chk("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
    chk("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    chk("rst_waddr", 64'(bus.waddr), 64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rst_instret", bus.instret, 64'd0);
    Rst_n = 1'b1;

    // ALU writeback
    set_instr(5'd5, 2'b00, 32'h1234, 3'd2, 32'h0);
    step();
    chk("alu_waddr", 64'(bus.waddr), 64'd5);
    chk("alu_wdata", 64'(bus.wdata), 64'h1234);
    chk("alu_RegWrite", 64'(bus.RegWrite), 64'd1);
    chk("alu_instret0", bus.instret, 64'd0);

    // Loads from 0x80FF7F01
    for (int i = 0; i < 5; i++) begin
      set_instr(5'd7, 2'b01, 32'h1000 + 32'(ld_off[i]), ld_f3[i], 32'h80FF_7F01);
      step();
      chk("load_wdata", 64'(bus.wdata), 64'(ld_exp[i]));
      if (i == 0) chk("alu_instret1", bus.instret, 64'd1);
    end

    // rd=0 never writes but still retires
    set_instr(5'd0, 2'b00, 32'hDEAD, 3'd2, 32'h0);
    step();
    chk("rd0_RegWrite", 64'(bus.RegWrite), 64'd0);
    chk("rd0_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    set_instr(5'd9, 2'b00, 32'hABCD, 3'd2, 32'h0);
    step();
    chk("rd0_instret", bus.instret, 64'd7);

    // stall+flush together: flush wins
    bus.stall = 1; bus.flush = 1;
    step();
    chk("sf_RegWrite", 64'(bus.RegWrite), 64'd0);
    bus.stall = 0; bus.flush = 0;
    step();
    chk("sf_instret", bus.instret, 64'd7);

    // three-cycle stall holds ABCD/rd9
    bus.stall = 1;
    set_instr(5'd3, 2'b10, 32'h5555, 3'd2, 32'h0);
    bus.pc_m = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wdata", 64'(bus.wdata), 64'hABCD);
      chk("stall_waddr", 64'(bus.waddr), 64'd9);
      chk("stall_RegWrite", 64'(bus.RegWrite), 64'd1);
      chk("stall_instret", bus.instret, 64'd7);
    end
    bus.stall = 0;
    step();
    chk("pc4_wrap_wdata", 64'(bus.wdata), 64'd0);
    chk("release_instret", bus.instret, 64'd8);

    // instret wrap and CSR low-half write
    bus.instret_we_lo = 1; bus.instret_we_hi = 1; bus.instret_wdata = 32'hFFFF_FFFF;
    step();
    chk("csr_all_ones", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.instret_we_lo = 0; bus.instret_we_hi = 0;
    step();
    chk("instret_wrap", bus.instret, 64'd0);
    bus.instret_we_lo = 1; bus.instret_wdata = 32'h10;
    step();
    chk("csr_lo_write", bus.instret, 64'h10);
    bus.instret_we_lo = 0;

    // async reset mid-cycle with a valid instruction in WB
    set_instr(5'd12, 2'b00, 32'h77, 3'd2, 32'h0);
    step();
    chk("pre_rst_RegWrite", 64'(bus.RegWrite), 64'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_RegWrite", 64'(bus.RegWrite), 64'd0);
    chk("arst_instret", bus.instret, 64'd0);
    chk("arst_wdata", 64'(bus.wdata), 64'd0);
    step(); step();
    Rst_n = 1'b1;
    set_instr(5'd13, 2'b00, 32'h99, 3'd2, 32'h0);
    step();
    chk("post_rst_capture", 64'(bus.wdata), 64'h99);
    chk("post_rst_instret", bus.instret, 64'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.valid_m       = ($urandom_range(0, 9) < 8);
      bus.RegWrite_m    = ($urandom_range(0, 9) < 8);
      bus.rd_m          = 5'($urandom_range(0, 31));
      bus.wb_sel_m      = 2'($urandom_range(0, 3));
      bus.alu_m         = $urandom;
      bus.pc_m          = $urandom;
      bus.csr_rdata_m   = $urandom;
      bus.dmem_rdata_m  = $urandom;
      bus.funct3_m      = 3'($urandom_range(0, 7));
      bus.stall         = ($urandom_range(0, 9) < 2);
      bus.flush         = ($urandom_range(0, 9) < 1);
      bus.instret_we_lo = ($urandom_range(0, 19) == 0);
      bus.instret_we_hi = ($urandom_range(0, 19) == 0);
      bus.instret_wdata = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
